// File: rtl/cep_ro_pkg.sv
// Shared definitions for the readout capture path.
// Holds the packer state encoding, the per-sample slot width inside a packed
// 32-bit word, and the layout of one FIFO entry (data word plus framing tags).
package cep_ro_pkg;

  localparam int PACK_SLOT_W = 16;

  typedef enum logic [1:0] {
    RP_IDLE    = 2'd0,
    RP_CAPTURE = 2'd1,
    RP_DRAIN   = 2'd2
  } rp_state_e;

  // One buffered word: 32-bit payload, start-of-line and end-of-frame tags.
  typedef struct packed {
    logic [31:0] data;
    logic        sol;
    logic        eof;
  } rp_word_t;

endpackage

// File: rtl/adc_row_packer_if.sv
// Output stream of the row packer toward the host-transfer path.
//   dout       : packed word (even sample [15:0], odd sample [31:16])
//   dout_valid : head word valid
//   dout_ready : consumer accepts the head word
//   dout_sol   : head word is the first word of a row
//   dout_eof   : head word is the last word of the frame
// master = packer side, slave = consumer side.
interface adc_row_packer_if;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_sol;
  logic        dout_eof;

  modport master (output dout, dout_valid, dout_sol, dout_eof, input dout_ready);
  modport slave  (input dout, dout_valid, dout_sol, dout_eof, output dout_ready);
endinterface

// File: rtl/ro_sync_fifo.sv
// Single-clock first-word fall-through FIFO.
//   clk, rst_n : clock and synchronous active-low reset (clears contents)
//   wr_en/wr_data : push request; accepted when not full, or when a pop
//                   happens on the same edge
//   rd_en      : pop the head entry (ignored while empty)
//   rd_data    : head entry, forced to 0 while empty
//   full/empty : occupancy flags
module ro_sync_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  assign do_rd = rd_en && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/adc_row_packer.sv
// ADC row packer: packs ADC samples in pairs into 32-bit words with row (sol)
// and frame (eof) tags and buffers them in a FWFT FIFO. ADC data cannot be
// stalled, so a push into a full FIFO drops the word and sets a sticky flag.
// Ports:
//   CLK, rst_n        : ADC output clock, synchronous active-low reset
//   arm               : pulse, starts one frame capture (ignored while busy)
//   NUM_SAMP, NUM_ROW : samples per row / rows per frame, latched on arm
//   adc_dat_valid/adc_dat : latency-aligned sample strobe and data
//   out_if            : output word stream (dout, valid/ready, sol, eof)
//   busy              : capturing or draining
//   frame_done        : one-cycle pulse once the frame is fully drained
//   overflow          : sticky, at least one word was dropped this frame
module adc_row_packer
  import cep_ro_pkg::*;
#(
  parameter int ADC_W      = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic [31:0]              NUM_SAMP,
  input  logic [31:0]              NUM_ROW,
  input  logic                     adc_dat_valid,
  input  logic [ADC_W-1:0]         adc_dat,
  adc_row_packer_if.master         out_if,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
);

  rp_state_e              state_q, state_d;
  logic [31:0]            nsamp_q, nsamp_d;
  logic [31:0]            nrow_q, nrow_d;
  logic [31:0]            samp_cnt_q, samp_cnt_d;
  logic [31:0]            row_cnt_q, row_cnt_d;
  logic                   half_q, half_d;
  logic [PACK_SLOT_W-1:0] low_q, low_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_done_q, frame_done_d;

  logic                   push;
  rp_word_t               push_word;
  rp_word_t               head;
  logic                   pop;
  logic                   fifo_full, fifo_empty;
  logic                   last_samp;
  logic [PACK_SLOT_W-1:0] samp16;

  assign samp16    = PACK_SLOT_W'(adc_dat);
  assign last_samp = (samp_cnt_q == nsamp_q - 32'd1);
  assign pop       = out_if.dout_valid && out_if.dout_ready;

  always_comb begin
    state_d      = state_q;
    nsamp_d      = nsamp_q;
    nrow_d       = nrow_q;
    samp_cnt_d   = samp_cnt_q;
    row_cnt_d    = row_cnt_q;
    half_d       = half_q;
    low_d        = low_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    push_word    = '0;

    case (state_q)
      RP_IDLE: begin
        if (arm) begin
          nsamp_d    = NUM_SAMP;
          nrow_d     = NUM_ROW;
          samp_cnt_d = '0;
          row_cnt_d  = '0;
          half_d     = 1'b0;
          overflow_d = 1'b0;
          // An empty frame completes immediately without ever going busy.
          if (NUM_SAMP == '0 || NUM_ROW == '0) frame_done_d = 1'b1;
          else                                 state_d      = RP_CAPTURE;
        end
      end

      RP_CAPTURE: begin
        if (adc_dat_valid) begin
          if (last_samp || half_q) begin
            push           = 1'b1;
            push_word.data = half_q ? {samp16, low_q} : {{PACK_SLOT_W{1'b0}}, samp16};
            // The first word of a row always holds sample 0 or 1.
            push_word.sol  = (samp_cnt_q[31:1] == '0);
          end
          if (last_samp) begin
            samp_cnt_d = '0;
            half_d     = 1'b0;
            if (row_cnt_q == nrow_q - 32'd1) begin
              push_word.eof = 1'b1;
              state_d       = RP_DRAIN;
            end else begin
              row_cnt_d = row_cnt_q + 32'd1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 32'd1;
            half_d     = ~half_q;
            if (!half_q) low_d = samp16;
          end
        end
      end

      RP_DRAIN: begin
        if (fifo_empty) begin
          state_d      = RP_IDLE;
          frame_done_d = 1'b1;
        end
      end

      default: state_d = RP_IDLE;
    endcase

    // A same-edge pop makes room, so only a truly blocked push is a loss.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q      <= RP_IDLE;
      nsamp_q      <= '0;
      nrow_q       <= '0;
      samp_cnt_q   <= '0;
      row_cnt_q    <= '0;
      half_q       <= 1'b0;
      low_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nsamp_q      <= nsamp_d;
      nrow_q       <= nrow_d;
      samp_cnt_q   <= samp_cnt_d;
      row_cnt_q    <= row_cnt_d;
      half_q       <= half_d;
      low_q        <= low_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  ro_sync_fifo #(
    .W     ($bits(rp_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_if.dout       = head.data;
  assign out_if.dout_sol   = head.sol;
  assign out_if.dout_eof   = head.eof;
  assign out_if.dout_valid = !fifo_empty;

  assign busy       = (state_q != RP_IDLE);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_row_packer.sv
// Bench for adc_row_packer: directed frames, expected words queued by the
// stimulus, a negedge monitor pops and compares every accepted word.
module tb_adc_row_packer;
  localparam int ADC_W = 14;

  logic             CLK = 1'b0;
  logic             rst_n;
  logic             arm;
  logic [31:0]      NUM_SAMP, NUM_ROW;
  logic             adc_dat_valid;
  logic [ADC_W-1:0] adc_dat;
  logic             busy, frame_done, overflow;

  adc_row_packer_if ifc ();

  adc_row_packer #(.ADC_W(ADC_W), .FIFO_DEPTH(8)) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .arm           (arm),
    .NUM_SAMP      (NUM_SAMP),
    .NUM_ROW       (NUM_ROW),
    .adc_dat_valid (adc_dat_valid),
    .adc_dat       (adc_dat),
    .out_if        (ifc),
    .busy          (busy),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int mon_sol = 0;
  int mon_eof = 0;
  logic [33:0] sb [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void expw(input logic [31:0] d, input logic s, input logic e);
    sb.push_back({d, s, e});
  endfunction

  // Scoreboard monitor: a word transfers at the next posedge when valid&&ready.
  always @(negedge CLK) begin
    if (rst_n && ifc.dout_valid && ifc.dout_ready) begin
      if (ifc.dout_sol) mon_sol++;
      if (ifc.dout_eof) mon_eof++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%0h sol=%0b eof=%0b expected none",
                 ifc.dout, ifc.dout_sol, ifc.dout_eof);
      end else begin
        chk("word", {30'd0, ifc.dout, ifc.dout_sol, ifc.dout_eof}, {30'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic arm_frame(input logic [31:0] ns, input logic [31:0] nr);
    NUM_SAMP = ns;
    NUM_ROW  = nr;
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
  endtask

  task automatic send(input logic [ADC_W-1:0] s);
    adc_dat_valid = 1'b1;
    adc_dat       = s;
    tick();
    adc_dat_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_frame_done_seen"}, 64'(found), 64'd1);
    chk({name, "_busy_low_with_done"}, 64'(busy), 64'd0);
    tick();
    chk({name, "_frame_done_one_cycle"}, 64'(frame_done), 64'd0);
  endtask

  function automatic logic [ADC_W-1:0] smp(input int r, input int i);
    return ADC_W'((r * 64 + i) * 37 + 5);
  endfunction

  initial begin
    rst_n = 1'b0; arm = 1'b0; adc_dat_valid = 1'b0; adc_dat = '0;
    NUM_SAMP = '0; NUM_ROW = '0; ifc.dout_ready = 1'b1;
    tick(); tick();
    chk("rst_dout_valid", 64'(ifc.dout_valid), 64'd0);
    chk("rst_dout", 64'(ifc.dout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    // 4 samples x 2 rows, back to back
    expw(32'h00020001, 1'b1, 1'b0);
    expw(32'h00040003, 1'b0, 1'b0);
    expw(32'h00060005, 1'b1, 1'b0);
    expw(32'h00080007, 1'b0, 1'b1);
    mon_sol = 0; mon_eof = 0;
    arm_frame(32'd4, 32'd2);
    chk("t1_busy_after_arm", 64'(busy), 64'd1);
    for (int i = 1; i <= 8; i++) send(ADC_W'(i));
    wait_done("t1", 50);
    chk("t1_sol_count", 64'(mon_sol), 64'd2);
    chk("t1_eof_count", 64'(mon_eof), 64'd1);

    // odd row length: unfilled high slot is zero; first-word latency
    expw(32'h000B000A, 1'b1, 1'b0);
    expw(32'h0000000C, 1'b0, 1'b1);
    arm_frame(32'd3, 32'd1);
    send(14'hA);
    send(14'hB);
    chk("t2_fwft_valid", 64'(ifc.dout_valid), 64'd1);
    chk("t2_fwft_dout", 64'(ifc.dout), 64'h000B000A);
    send(14'hC);
    wait_done("t2", 50);

    // stalled consumer: 10 words into 8 entries, 2 dropped
    ifc.dout_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      expw({16'(2*i+2), 16'(2*i+1)}, (i == 0), 1'b0);
    arm_frame(32'd20, 32'd1);
    for (int i = 1; i <= 20; i++) send(ADC_W'(i));
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_valid_held", 64'(ifc.dout_valid), 64'd1);
    tick(); tick(); tick();
    chk("t3_drain_busy", 64'(busy), 64'd1);
    chk("t3_drain_no_done", 64'(frame_done), 64'd0);
    ifc.dout_ready = 1'b1;
    wait_done("t3", 50);
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);

    // zero rows: immediate done, never busy, overflow cleared by arm
    arm_frame(32'd4, 32'd0);
    chk("t4_done_next", 64'(frame_done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_valid", 64'(ifc.dout_valid), 64'd0);
    chk("t4_overflow_cleared", 64'(overflow), 64'd0);
    tick();
    chk("t4_done_pulse", 64'(frame_done), 64'd0);
    chk("t4_busy_after", 64'(busy), 64'd0);

    // reset mid-frame with 3 words buffered
    ifc.dout_ready = 1'b0;
    arm_frame(32'd8, 32'd2);
    for (int i = 1; i <= 6; i++) send(ADC_W'(i));
    chk("t5_pre_valid", 64'(ifc.dout_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("t5_valid", 64'(ifc.dout_valid), 64'd0);
    chk("t5_dout", 64'(ifc.dout), 64'd0);
    chk("t5_tags", 64'({ifc.dout_sol, ifc.dout_eof}), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_flags", 64'({frame_done, overflow}), 64'd0);
    rst_n = 1'b1;
    ifc.dout_ready = 1'b1;
    tick();
    expw(32'h00120011, 1'b1, 1'b0);
    expw(32'h00140013, 1'b0, 1'b1);
    arm_frame(32'd4, 32'd1);
    for (int i = 0; i < 4; i++) send(ADC_W'(8'h11 + i));
    wait_done("t5", 50);

    // 64x4 frame, random ready, stray arm mid-capture
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 32; p++)
        expw({16'(smp(r, 2*p+1)), 16'(smp(r, 2*p))}, (p == 0), (r == 3 && p == 31));
    mon_sol = 0; mon_eof = 0;
    arm_frame(32'd64, 32'd4);
    for (int k = 0; k < 256; k++) begin
      if (k == 100) begin
        arm = 1'b1; NUM_SAMP = 32'd2; NUM_ROW = 32'd1;
      end
      ifc.dout_ready = ($urandom_range(3) != 0);
      send(smp(k / 64, k % 64));
      arm = 1'b0;
      ifc.dout_ready = ($urandom_range(3) != 0);
      tick();
    end
    chk("t6_busy_after_stray_arm", 64'(busy), 64'd1);
    ifc.dout_ready = 1'b1;
    wait_done("t6", 200);
    chk("t6_sol_count", 64'(mon_sol), 64'd4);
    chk("t6_eof_count", 64'(mon_eof), 64'd1);
    chk("t6_no_overflow", 64'(overflow), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_row_packer.md
# adc_row_packer

Capture-side counterpart to the pixel readout sequencer. It runs in the ADC output-clock domain and consumes the delayed `adc_dat_valid` strobe and ADC samples that the readout timing produces. It packs the samples into 32-bit words with row and frame framing and buffers them in a small FIFO for the host-transfer path. ADC data cannot be stalled, so backpressure is absorbed by the FIFO and any loss is flagged.

## Interface
Parameters:
- `ADC_W`, 14: ADC sample width, ≤16.
- `FIFO_DEPTH`, 8: output FIFO entries, power of two, ≥4.

Ports:
- `CLK` in 1: ADC output clock (`adc1_out_clk` or `adc2_out_clk`); the only clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `arm` in 1: single-cycle pulse that starts capture of one frame.
- `NUM_SAMP` in 32: samples per row, left and right banks combined.
- `NUM_ROW` in 32: rows per frame.
- `adc_dat_valid` in 1: sample-valid strobe, already latency-aligned.
- `adc_dat` in `ADC_W`: ADC sample.
- `dout` out 32: packed word; even sample in [15:0], odd sample in [31:16], each zero-extended.
- `dout_valid` out 1: FIFO head valid.
- `dout_ready` in 1: consumer accept.
- `dout_sol` out 1: head word is the first word of a row.
- `dout_eof` out 1: head word is the last word of the frame.
- `busy` out 1: high in CAPTURE and DRAIN.
- `frame_done` out 1: one-cycle pulse when the frame has been fully drained.
- `overflow` out 1: sticky; a word was dropped.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `adc_dat_valid` is ignored.
  - On `arm`: latch `NUM_SAMP`/`NUM_ROW`, clear `samp_cnt`, `row_cnt`, `half` and `overflow`, then go to CAPTURE.
  - If either latched count is 0: emit a `frame_done` pulse on the next cycle, push no words, stay in IDLE.
- CAPTURE, on each `adc_dat_valid`:
  - `half`=0: store the sample in the low slot.
  - `half`=1: complete the word and push it.
  - `samp_cnt`==NUM_SAMP−1: push the word regardless of `half`. An unfilled high slot is 0. Then reset `samp_cnt` and `half` and increment `row_cnt`.
  - The first push of each row carries sol=1.
  - The final push of the last row (`row_cnt`==NUM_ROW−1) carries eof=1, then the state goes to DRAIN.
- DRAIN: wait for the FIFO to empty, then pulse `frame_done` for one cycle and go to IDLE. `adc_dat_valid` is ignored.
- `arm` is ignored while `busy`.
- FIFO full on push: drop the word (including its sol/eof tags) and set `overflow`. Counters still advance, so framing recovers on the next row.
- Counters are 32-bit unsigned; comparisons use the latched values.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State becomes IDLE; FIFO, counters and `half` are cleared.
  - `dout_valid`, `dout_sol`, `dout_eof`, `busy`, `frame_done` and `overflow` are 0; `dout` is 0.
  - Mid-frame reset discards all buffered words.
- `busy` goes high the edge after `arm`.
- A push triggered by the sample captured at edge k is written at edge k. With the FIFO empty, `dout_valid`, `dout` and the tags are visible after edge k (first-word fall-through, 1-cycle latency).
- A pop occurs at an edge where `dout_valid && dout_ready`.
- Simultaneous push and pop with the FIFO full: the pop wins, the push succeeds, and no overflow is recorded.
- `frame_done` asserts the cycle after the FIFO becomes empty in DRAIN. `busy` drops together with the `frame_done` pulse.
- Back-to-back `adc_dat_valid` every cycle is supported; sustained throughput is 1 word per 2 samples.

## Structure
- Shared package `cep_ro_pkg` holds the state encoding constants (`RP_IDLE`, `RP_CAPTURE`, `RP_DRAIN`) and `PACK_SLOT_W`=16.
- Sub-module `ro_sync_fifo`: single-clock, first-word fall-through FIFO, width 34 (`dout`, sol, eof), depth `FIFO_DEPTH`, with full and empty outputs.
- Packer FSM and counters sit in the top module.

## Test plan
- NUM_SAMP=4, NUM_ROW=2, samples 1..8 every cycle, `dout_ready`=1 → words 0x00020001 (sol), 0x00040003, 0x00060005 (sol), 0x00080007 (eof); then one `frame_done` pulse and `busy`=0.
- NUM_SAMP=3, NUM_ROW=1, samples 0xA,0xB,0xC → words 0x000B000A (sol), 0x0000000C (eof).
- `dout_ready`=0, NUM_SAMP=20, NUM_ROW=1, FIFO_DEPTH=8 → 8 words buffered, 2 dropped, `overflow`=1; the state stays in DRAIN until `dout_ready`=1 empties the FIFO, then `frame_done`.
- NUM_ROW=0, `arm` pulse → `frame_done` on the next cycle, `dout_valid` never high, `busy` never high.
- `rst_n`=0 after 3 of 8 words pushed → all outputs 0 on the next cycle; a subsequent `arm` produces a clean frame starting with sol.
- `arm` pulsed during CAPTURE, with random `dout_ready` over a 64×4 frame → ignored; all 128 words match the scoreboard, with 4 sol and 1 eof.
